wr_circ_buf_ctrl: RTL

//  Write-side engine for a NoC-backed circular buffer (e.g. TCP payload buffer). Takes one write request (buffer offset + byte count)
//  and its packed source data lines. Issues NoC write requests plus line data; a write crossing the buffer end is split into two

---
 rtl/wr_circ_buf_ctrl_if.sv | 62 ++++++
 rtl/wr_circ_buf_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wr_circ_buf_ctrl_if.sv
// Handshake bundle between the write-buffer controller, its data source
// and the NoC write port. The controller uses the master view.
interface wr_circ_buf_ctrl_if #(
    parameter int DATA_W    = 512,
    parameter int BUF_PTR_W = 12,
    parameter int SIZE_W    = 16
) ();
    logic                 src_wr_buf_req_val;
    logic                 src_wr_buf_req_rdy;
    logic [BUF_PTR_W-1:0] src_wr_buf_req_addr;
    logic [SIZE_W-1:0]    src_wr_buf_req_size;

    logic                 src_wr_buf_data_val;
    logic                 src_wr_buf_data_rdy;
    logic [DATA_W-1:0]    src_wr_buf_data;

    logic                 ctrl_wr_noc_req_val;
    logic                 ctrl_wr_noc_req_rdy;
    logic [BUF_PTR_W-1:0] ctrl_wr_noc_req_addr;
    logic [SIZE_W-1:0]    ctrl_wr_noc_req_size;

    logic                 ctrl_wr_noc_data_val;
    logic                 ctrl_wr_noc_data_rdy;
    logic [DATA_W-1:0]    ctrl_wr_noc_data;
    logic                 ctrl_wr_noc_data_last;

    logic                 wr_noc_ctrl_done_val;
    logic                 ctrl_wr_noc_done_rdy;

    logic                 wr_buf_src_done_val;
    logic                 wr_buf_src_done_rdy;

    modport master (
        input  src_wr_buf_req_val, src_wr_buf_req_addr, src_wr_buf_req_size,
        output src_wr_buf_req_rdy,
        input  src_wr_buf_data_val, src_wr_buf_data,
        output src_wr_buf_data_rdy,
        output ctrl_wr_noc_req_val, ctrl_wr_noc_req_addr, ctrl_wr_noc_req_size,
        input  ctrl_wr_noc_req_rdy,
        output ctrl_wr_noc_data_val, ctrl_wr_noc_data, ctrl_wr_noc_data_last,
        input  ctrl_wr_noc_data_rdy,
        input  wr_noc_ctrl_done_val,
        output ctrl_wr_noc_done_rdy,
        output wr_buf_src_done_val,
        input  wr_buf_src_done_rdy
    );

    modport slave (
        output src_wr_buf_req_val, src_wr_buf_req_addr, src_wr_buf_req_size,
        input  src_wr_buf_req_rdy,
        output src_wr_buf_data_val, src_wr_buf_data,
        input  src_wr_buf_data_rdy,
        input  ctrl_wr_noc_req_val, ctrl_wr_noc_req_addr, ctrl_wr_noc_req_size,
        output ctrl_wr_noc_req_rdy,
        input  ctrl_wr_noc_data_val, ctrl_wr_noc_data, ctrl_wr_noc_data_last,
        output ctrl_wr_noc_data_rdy,
        output wr_noc_ctrl_done_val,
        input  ctrl_wr_noc_done_rdy,
        input  wr_buf_src_done_val,
        output wr_buf_src_done_rdy
    );
endinterface

// File: rtl/wr_circ_buf_ctrl.sv
// Write-side engine for a circular buffer behind a NoC. One source request
// becomes one NoC write, or two when it wraps past the buffer end; the
// second segment is re-packed from byte 0 using a one-line hold register.
module wr_circ_buf_ctrl #(
    parameter int DATA_W    = 512,
    parameter int BUF_PTR_W = 12,
    parameter int SIZE_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wr_circ_buf_ctrl_if.master    bus
);
    localparam int B     = DATA_W / 8;
    localparam int LOG_B = $clog2(B);
    localparam int SH_W  = LOG_B + 4;
    localparam logic [BUF_PTR_W:0] BUF_END   = {1'b1, {BUF_PTR_W{1'b0}}};
    localparam logic [SIZE_W-1:0]  BUF_BYTES = SIZE_W'(BUF_END);
    localparam logic [SIZE_W-1:0]  B_SZ      = SIZE_W'(B);

    typedef enum logic [2:0] {IDLE, REQ0, DATA0, REQ1, DATA1, WAIT_RESP, DONE} state_t;

    state_t               state_q, state_d;
    logic [BUF_PTR_W-1:0] addr_q;
    logic [SIZE_W-1:0]    len0_q, len1_q, rem_q;
    logic                 split_q;
    logic [LOG_B-1:0]     r_q;
    logic [1:0]           need_q, done_cnt_q;
    logic [DATA_W-1:0]    hold_q;

    // Zero every byte at index n or above (tail of the segment's last line).
    function automatic logic [DATA_W-1:0] mask_tail(input logic [DATA_W-1:0] d,
                                                    input logic [SIZE_W-1:0] n);
        logic [DATA_W-1:0] m;
        m = d;
        for (int i = 0; i < B; i++)
            if (SIZE_W'(i) >= n) m[8*i +: 8] = 8'h00;
        return m;
    endfunction

    // Request decode, evaluated on the accept cycle.
    logic [BUF_PTR_W:0] end_sum;
    logic               split_in;
    logic [SIZE_W-1:0]  len0_in;
    assign end_sum  = {1'b0, bus.src_wr_buf_req_addr} + bus.src_wr_buf_req_size[BUF_PTR_W:0];
    assign split_in = end_sum > BUF_END;
    assign len0_in  = split_in ? BUF_BYTES - SIZE_W'(bus.src_wr_buf_req_addr)
                               : bus.src_wr_buf_req_size;

    logic req_acc, noc_req_fire, noc_data_fire, src_data_fire, pulse, seg_last, drain;
    logic [2:0] done_sum;
    assign req_acc       = bus.src_wr_buf_req_val && bus.src_wr_buf_req_rdy;
    assign noc_req_fire  = bus.ctrl_wr_noc_req_val && bus.ctrl_wr_noc_req_rdy;
    assign noc_data_fire = bus.ctrl_wr_noc_data_val && bus.ctrl_wr_noc_data_rdy;
    assign src_data_fire = bus.src_wr_buf_data_val && bus.src_wr_buf_data_rdy;
    assign pulse         = bus.wr_noc_ctrl_done_val && bus.ctrl_wr_noc_done_rdy;
    assign seg_last      = rem_q <= B_SZ;
    // Remaining second-segment bytes all sit in the hold register already.
    assign drain         = rem_q <= (B_SZ - SIZE_W'(r_q));
    assign done_sum      = {1'b0, done_cnt_q} + {2'b00, pulse};

    // Unaligned second segment: upper part of the held line, then the low part of the new line.
    logic [DATA_W-1:0] hold_sh, src_sh;
    logic [SH_W-1:0]   hi_sh;
    assign hi_sh   = SH_W'(DATA_W) - SH_W'({r_q, 3'b000});
    assign hold_sh = hold_q >> {r_q, 3'b000};
    assign src_sh  = bus.src_wr_buf_data << hi_sh;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_acc)
                           state_d = (bus.src_wr_buf_req_size == '0) ? WAIT_RESP : REQ0;
            REQ0:      if (noc_req_fire) state_d = DATA0;
            DATA0:     if (noc_data_fire && seg_last) state_d = split_q ? REQ1 : WAIT_RESP;
            REQ1:      if (noc_req_fire) state_d = DATA1;
            DATA1:     if (noc_data_fire && seg_last) state_d = WAIT_RESP;
            WAIT_RESP: if (done_sum >= {1'b0, need_q}) state_d = DONE;
            DONE:      if (bus.wr_buf_src_done_rdy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic; every handshake output is held low during reset.
    always_comb begin
        logic [DATA_W-1:0] data_raw;
        data_raw                  = bus.src_wr_buf_data;
        bus.src_wr_buf_req_rdy    = 1'b0;
        bus.src_wr_buf_data_rdy   = 1'b0;
        bus.ctrl_wr_noc_req_val   = 1'b0;
        bus.ctrl_wr_noc_req_addr  = addr_q;
        bus.ctrl_wr_noc_req_size  = len0_q;
        bus.ctrl_wr_noc_data_val  = 1'b0;
        bus.ctrl_wr_noc_data_last = seg_last;
        bus.ctrl_wr_noc_done_rdy  = 1'b0;
        bus.wr_buf_src_done_val   = 1'b0;
        if (!rst) begin
            bus.ctrl_wr_noc_done_rdy = (state_q != IDLE);
            case (state_q)
                IDLE: bus.src_wr_buf_req_rdy = 1'b1;
                REQ0: bus.ctrl_wr_noc_req_val = 1'b1;
                DATA0: begin
                    bus.ctrl_wr_noc_data_val = bus.src_wr_buf_data_val;
                    bus.src_wr_buf_data_rdy  = bus.ctrl_wr_noc_data_rdy;
                end
                REQ1: begin
                    bus.ctrl_wr_noc_req_val  = 1'b1;
                    bus.ctrl_wr_noc_req_addr = '0;
                    bus.ctrl_wr_noc_req_size = len1_q;
                end
                DATA1: begin
                    if (r_q == '0) begin
                        bus.ctrl_wr_noc_data_val = bus.src_wr_buf_data_val;
                        bus.src_wr_buf_data_rdy  = bus.ctrl_wr_noc_data_rdy;
                    end else if (drain) begin
                        bus.ctrl_wr_noc_data_val = 1'b1;
                        data_raw                 = hold_sh;
                    end else begin
                        bus.ctrl_wr_noc_data_val = bus.src_wr_buf_data_val;
                        bus.src_wr_buf_data_rdy  = bus.ctrl_wr_noc_data_rdy;
                        data_raw                 = hold_sh | src_sh;
                    end
                end
                DONE: bus.wr_buf_src_done_val = 1'b1;
                default: ;
            endcase
        end
        bus.ctrl_wr_noc_data = mask_tail(data_raw, rem_q);
    end

    // Request bookkeeping: latched geometry, bytes left in the segment, completions seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            len0_q     <= '0;
            len1_q     <= '0;
            rem_q      <= '0;
            split_q    <= 1'b0;
            r_q        <= '0;
            need_q     <= '0;
            done_cnt_q <= '0;
        end else begin
            if (req_acc) begin
                addr_q     <= bus.src_wr_buf_req_addr;
                len0_q     <= len0_in;
                len1_q     <= bus.src_wr_buf_req_size - len0_in;
                rem_q      <= len0_in;
                split_q    <= split_in;
                r_q        <= len0_in[LOG_B-1:0];
                need_q     <= (bus.src_wr_buf_req_size == '0) ? 2'd0 : (split_in ? 2'd2 : 2'd1);
                done_cnt_q <= '0;
            end
            if (pulse) done_cnt_q <= done_sum[1:0];
            if (noc_data_fire) rem_q <= seg_last ? len1_q : rem_q - B_SZ;
        end
    end

    // Hold register always keeps the most recently consumed source line.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath register, never read before a line is captured, so it needs no reset.
        if (src_data_fire) hold_q <= bus.src_wr_buf_data;
    end
endmodule
